// File: rtl/guess_pkg.sv
// ----------------------------------------------------------------------------
// guess_pkg
// Shared types and constants for the number-guessing player datapath.
//   state_e      : engine state (IDLE / DRAW / PLAY / LOCK)
//   hint_e       : hint encoding driven on the hint output
//   LIMIT_*D     : exclusive upper bound of the secret for 1/2/3 digits
//   digit_mask   : LFSR bit mask used to form a draw candidate
//   digit_limit  : exclusive upper bound selected by max_digit
// ----------------------------------------------------------------------------
package guess_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    PLAY = 2'd2,
    LOCK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    H_NONE = 2'b00,
    H_LOW  = 2'b01,
    H_HIGH = 2'b10,
    H_EQ   = 2'b11
  } hint_e;

  localparam logic [9:0] LIMIT_1D = 10'd10;
  localparam logic [9:0] LIMIT_2D = 10'd100;
  localparam logic [9:0] LIMIT_3D = 10'd1000;

  // Narrowest power-of-two mask that covers the digit range, so rejection
  // sampling accepts the candidate with high probability.
  function automatic logic [9:0] digit_mask(input logic [1:0] max_digit);
    logic [9:0] m;
    case (max_digit)
      2'd1:    m = 10'h00F;
      2'd2:    m = 10'h07F;
      2'd3:    m = 10'h3FF;
      default: m = 10'h000;
    endcase
    return m;
  endfunction

  function automatic logic [9:0] digit_limit(input logic [1:0] max_digit);
    logic [9:0] l;
    case (max_digit)
      2'd1:    l = LIMIT_1D;
      2'd2:    l = LIMIT_2D;
      2'd3:    l = LIMIT_3D;
      default: l = 10'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/lfsr10.sv
// ----------------------------------------------------------------------------
// lfsr10
// Free-running 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1 (maximal
// length, 1023 states). Advances every clock; SEED must be non-zero.
// Ports:
//   clk     : system clock
//   restart : synchronous active-high reset, loads SEED
//   q       : current register value
// ----------------------------------------------------------------------------
module lfsr10 #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       restart,
  output logic [9:0] q
);

  logic [9:0] q_q;
  logic [9:0] q_d;

  // Shift left, feeding back the XOR of taps 10 and 7.
  always_comb begin
    q_d = {q_q[8:0], q_q[9] ^ q_q[6]};
  end

  // Shift register with synchronous reload of the seed.
  always_ff @(posedge clk) begin
    if (restart) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/guess_engine.sv
// ----------------------------------------------------------------------------
// guess_engine
// Player-side datapath of the number-guessing game: draws a secret, grades
// confirmed entries, counts guesses/rounds and runs the seconds countdown.
// Build option: define GUESS_ENGINE_REVEAL_EN to add secret_out (debug view
// of the registered secret); without it the secret never leaves the block.
// Ports:
//   clk           : system clock
//   restart       : synchronous active-high reset
//   max_guess     : allowed wrong guesses at this level
//   max_digit     : secret digit count (0 = no level)
//   guess_val     : player entry, unsigned binary
//   comfirmButton : raw confirm button, one evaluation per rising level
//   guess         : guesses used in the current round
//   round         : rounds won at the current level
//   timer         : seconds remaining
//   hint          : 00 none, 01 too low, 10 too high, 11 correct
//   busy          : high while drawing a secret
//   secret_out    : (reveal build only) registered secret
// ----------------------------------------------------------------------------
module guess_engine
  import guess_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SECS_PER_DIGIT = 30,
  parameter logic [9:0]  LFSR_SEED      = 10'h2A5
) (
  input  logic       clk,
  input  logic       restart,
  input  logic [2:0] max_guess,
  input  logic [1:0] max_digit,
  input  logic [9:0] guess_val,
  input  logic       comfirmButton,
  output logic [2:0] guess,
  output logic [2:0] round,
  output logic [6:0] timer,
  output logic [1:0] hint,
  output logic       busy
`ifdef GUESS_ENGINE_REVEAL_EN
  ,
  output logic [9:0] secret_out
`endif
);

  localparam logic [31:0] PRESC_TC = 32'(CLK_HZ - 32'd1);

  state_e      state_q, state_d;
  logic [2:0]  guess_q, guess_d;
  logic [2:0]  round_q, round_d;
  logic [6:0]  timer_q, timer_d;
  hint_e       hint_q, hint_d;
  logic        busy_q, busy_d;
  logic [9:0]  secret_q, secret_d;
  logic [31:0] presc_q, presc_d;
  logic [1:0]  prev_digit_q;
  logic        prev_btn_q;

  logic [9:0]  lfsr_s;
  logic [9:0]  cand_s;
  logic        cand_ok_s;
  logic        level_chg_s;
  logic        confirm_s;
  logic        running_s;
  logic        tick_s;
  logic        expire_s;
  logic        eval_s;
  logic        match_s;
  logic        draw_hit_s;
  logic [2:0]  guess_inc_s;
  logic [2:0]  round_inc_s;
  logic [6:0]  timer_load_s;

  lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .restart (restart),
    .q       (lfsr_s)
  );

  assign level_chg_s  = (max_digit != prev_digit_q);
  assign confirm_s    = comfirmButton & ~prev_btn_q;
  assign running_s    = (state_q == DRAW) || (state_q == PLAY);
  assign tick_s       = running_s && (presc_q == PRESC_TC);
  // Expiry is the tick that takes the timer to zero; a zero timer while
  // running (degenerate SECS_PER_DIGIT) also counts as expired.
  assign expire_s     = running_s && ((timer_q == 7'd0) || (tick_s && (timer_q == 7'd1)));
  assign cand_s       = lfsr_s & digit_mask(max_digit);
  assign cand_ok_s    = (cand_s < digit_limit(max_digit));
  // Expiry outranks both grading and drawing in the same cycle.
  assign eval_s       = (state_q == PLAY) && confirm_s && !expire_s;
  assign draw_hit_s   = (state_q == DRAW) && cand_ok_s && !expire_s;
  assign match_s      = (guess_val == secret_q);
  assign guess_inc_s  = (guess_q == 3'd7) ? 3'd7 : (guess_q + 3'd1);
  assign round_inc_s  = (round_q == 3'd7) ? 3'd7 : (round_q + 3'd1);
  assign timer_load_s = 7'({30'd0, max_digit} * SECS_PER_DIGIT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (restart) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: level change, then expiry, then per-state behaviour.
  always_comb begin
    state_d = state_q;
    if (level_chg_s) begin
      if (max_digit == 2'd0) begin
        state_d = IDLE;
      end else begin
        state_d = DRAW;
      end
    end else if (expire_s) begin
      state_d = LOCK;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        DRAW: begin
          if (cand_ok_s) begin
            state_d = PLAY;
          end else begin
            state_d = DRAW;
          end
        end
        PLAY: begin
          if (eval_s && match_s) begin
            state_d = DRAW;
          end else if (eval_s && (guess_inc_s > max_guess)) begin
            state_d = LOCK;
          end else begin
            state_d = PLAY;
          end
        end
        LOCK:    state_d = LOCK;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath next values: level reload, countdown, grading, draw.
  always_comb begin
    guess_d  = guess_q;
    round_d  = round_q;
    timer_d  = timer_q;
    hint_d   = hint_q;
    presc_d  = presc_q;
    secret_d = secret_q;
    busy_d   = (state_d == DRAW);
    if (level_chg_s) begin
      guess_d = 3'd0;
      round_d = 3'd0;
      hint_d  = H_NONE;
      timer_d = timer_load_s;
      presc_d = 32'd0;
    end else begin
      if (running_s) begin
        if (tick_s) begin
          presc_d = 32'd0;
          if (timer_q != 7'd0) begin
            timer_d = timer_q - 7'd1;
          end else begin
            timer_d = timer_q;
          end
        end else begin
          presc_d = presc_q + 32'd1;
        end
      end else begin
        presc_d = presc_q;
      end

      if (eval_s) begin
        if (match_s) begin
          hint_d  = H_EQ;
          round_d = round_inc_s;
          guess_d = 3'd0;
        end else if (guess_val < secret_q) begin
          hint_d  = H_LOW;
          guess_d = guess_inc_s;
        end else begin
          hint_d  = H_HIGH;
          guess_d = guess_inc_s;
        end
      end else begin
        guess_d = guess_q;
      end

      if (draw_hit_s) begin
        secret_d = cand_s;
      end else begin
        secret_d = secret_q;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (restart) begin
      guess_q      <= 3'd0;
      round_q      <= 3'd0;
      timer_q      <= 7'd0;
      hint_q       <= H_NONE;
      busy_q       <= 1'b0;
      secret_q     <= 10'd0;
      presc_q      <= 32'd0;
      prev_digit_q <= 2'd0;
      prev_btn_q   <= 1'b0;
    end else begin
      guess_q      <= guess_d;
      round_q      <= round_d;
      timer_q      <= timer_d;
      hint_q       <= hint_d;
      busy_q       <= busy_d;
      secret_q     <= secret_d;
      presc_q      <= presc_d;
      prev_digit_q <= max_digit;
      prev_btn_q   <= comfirmButton;
    end
  end

  assign guess = guess_q;
  assign round = round_q;
  assign timer = timer_q;
  assign hint  = hint_q;
  assign busy  = busy_q;

`ifdef GUESS_ENGINE_REVEAL_EN
  assign secret_out = secret_q;
`endif

endmodule
